// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: producer class encodings,
// the class-to-latency map and the pending-counter width helpers.
package hazard_pkg;

  localparam logic [1:0] CLS_ALU  = 2'd0;
  localparam logic [1:0] CLS_LOAD = 2'd1;
  localparam logic [1:0] CLS_MDU  = 2'd2;

  localparam int DEF_LOAD_LAT = 1;
  localparam int DEF_MDU_LAT  = 4;

  // Width needed to hold the largest producer latency (at least one bit).
  function automatic int pend_w_of(input int load_lat, input int mdu_lat);
    int max_lat;
    max_lat = (load_lat > mdu_lat) ? load_lat : mdu_lat;
    return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
  endfunction

  localparam int PEND_W = pend_w_of(DEF_LOAD_LAT, DEF_MDU_LAT);

  // Cycles after issue before the result can be forwarded.
  // The reserved class encoding behaves like an ALU op.
  function automatic int lat_of(input logic [1:0] cls, input int load_lat, input int mdu_lat);
    case (cls)
      CLS_ALU:  return 0;
      CLS_LOAD: return load_lat;
      CLS_MDU:  return mdu_lat;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/reg_pending_ctr.sv
// Pending-write down-counter for one architectural register.
// Loads the producer latency on issue, otherwise counts down to zero;
// freezes entirely while the pipeline is held.
module reg_pending_ctr
  import hazard_pkg::*;
#(
  parameter int W = PEND_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_hold,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Load wins over decrement so a fresh issue is never shortened by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_hold) begin
      if (i_load) begin
        r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - W'(1);
      end
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard for variable-latency producers (ALU / LOAD / MDU).
// Stalls ID on RAW hazards and on WAW hazards where a younger, shorter op
// could otherwise retire before an older, longer one to the same rd.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_NUM  = 32,
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MDU_LAT  = 4,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [ADDR_W-1:0]  id_rs1_addr,
  input  logic [ADDR_W-1:0]  id_rs2_addr,
  input  logic               id_rs1_used,
  input  logic               id_rs2_used,
  input  logic [ADDR_W-1:0]  id_rd_addr,
  input  logic               id_reg_write,
  input  logic [1:0]         id_class,
  input  logic               flush,
  input  logic               global_stall,
  output logic               pause,
  output logic               bubble,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [REG_NUM-1:0] busy_mask
);

  localparam int PW     = pend_w_of(LOAD_LAT, MDU_LAT);
  localparam int ASPACE = 1 << ADDR_W;

  // Indexed by the full address space so out-of-range addresses read as idle.
  logic [PW-1:0]    w_pend [ASPACE];
  logic [PW-1:0]    w_lat;
  logic             w_raw;
  logic             w_waw;
  logic             w_pause;
  logic             w_issue;
  logic [CNT_W-1:0] r_stall_cycles;

  // Latency the ID instruction would load into its destination counter.
  always_comb begin
    w_lat = PW'(lat_of(id_class, LOAD_LAT, MDU_LAT));
  end

  // Hazard detection and issue qualification from registered state + ID inputs.
  always_comb begin
    w_raw   = id_valid &
              ((id_rs1_used & (id_rs1_addr != '0) & (w_pend[id_rs1_addr] != '0)) |
               (id_rs2_used & (id_rs2_addr != '0) & (w_pend[id_rs2_addr] != '0)));
    w_waw   = id_valid & id_reg_write & (id_rd_addr != '0) &
              (w_pend[id_rd_addr] > w_lat);
    w_pause = (w_raw | w_waw) & ~flush;
    w_issue = id_valid & id_reg_write & (id_rd_addr != '0) &
              ~w_pause & ~flush & ~global_stall;
  end

  // One pending counter per writable register; x0 and unmapped addresses tie to zero.
  for (genvar g = 0; g < ASPACE; g++) begin : g_reg
    if (g == 0 || g >= REG_NUM) begin : g_zero
      assign w_pend[g] = '0;
    end else begin : g_ctr
      reg_pending_ctr #(.W(PW)) u_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_hold     (global_stall),
        .i_load     (w_issue && (id_rd_addr == ADDR_W'(g))),
        .i_load_val (w_lat),
        .o_cnt      (w_pend[g])
      );
    end
  end

  for (genvar g = 0; g < REG_NUM; g++) begin : g_busy
    assign busy_mask[g] = (w_pend[g] != '0);
  end

  // Saturating count of cycles in which ID was actually held by a hazard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (w_pause && !global_stall && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign pause        = w_pause;
  assign bubble       = w_pause;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus a
// randomized run against a time-stamp based reference model.
module tb_hazard_scoreboard;

  localparam int REG_NUM  = 32;
  localparam int ADDR_W   = 5;
  localparam int LOAD_LAT = 1;
  localparam int MDU_LAT  = 4;
  localparam int CNT_W    = 32;

  localparam logic [1:0] C_ALU  = 2'd0;
  localparam logic [1:0] C_LOAD = 2'd1;
  localparam logic [1:0] C_MDU  = 2'd2;

  logic               clk;
  logic               rst_n;
  logic               id_valid;
  logic [ADDR_W-1:0]  id_rs1_addr;
  logic [ADDR_W-1:0]  id_rs2_addr;
  logic               id_rs1_used;
  logic               id_rs2_used;
  logic [ADDR_W-1:0]  id_rd_addr;
  logic               id_reg_write;
  logic [1:0]         id_class;
  logic               flush;
  logic               global_stall;
  logic               pause;
  logic               bubble;
  logic [CNT_W-1:0]   stall_cycles;
  logic [REG_NUM-1:0] busy_mask;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: each register remembers the (frozen-time) instant its
  // result becomes forwardable; time only advances on non-stalled cycles.
  int ready_at [REG_NUM];
  int now;
  int m_stall;

  hazard_scoreboard #(
    .REG_NUM(REG_NUM), .ADDR_W(ADDR_W), .LOAD_LAT(LOAD_LAT),
    .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
    .id_class(id_class), .flush(flush), .global_stall(global_stall),
    .pause(pause), .bubble(bubble), .stall_cycles(stall_cycles),
    .busy_mask(busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic int lat(input logic [1:0] c);
    if (c == C_LOAD) return LOAD_LAT;
    if (c == C_MDU)  return MDU_LAT;
    return 0;
  endfunction

  function automatic int remaining(input int r);
    if (r == 0 || r >= REG_NUM) return 0;
    return (ready_at[r] > now) ? ready_at[r] - now : 0;
  endfunction

  function automatic logic m_pause();
    logic raw, waw;
    raw = id_valid && ((id_rs1_used && remaining(int'(id_rs1_addr)) > 0) ||
                       (id_rs2_used && remaining(int'(id_rs2_addr)) > 0));
    waw = id_valid && id_reg_write && id_rd_addr != 0 &&
          remaining(int'(id_rd_addr)) > lat(id_class);
    return (raw || waw) && !flush;
  endfunction

  function automatic logic [REG_NUM-1:0] m_busy();
    logic [REG_NUM-1:0] b;
    b = '0;
    for (int r = 1; r < REG_NUM; r++) b[r] = (remaining(r) > 0);
    return b;
  endfunction

  task automatic idle();
    id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_used = 0;
    id_rs2_used = 0; id_rd_addr = 0; id_reg_write = 0; id_class = C_ALU;
    flush = 0; global_stall = 0;
  endtask

  task automatic drive(input logic v, input int rs1, input logic u1, input int rs2,
                       input logic u2, input int rd, input logic we, input logic [1:0] cls);
    id_valid = v; id_rs1_addr = ADDR_W'(rs1); id_rs1_used = u1;
    id_rs2_addr = ADDR_W'(rs2); id_rs2_used = u2; id_rd_addr = ADDR_W'(rd);
    id_reg_write = we; id_class = cls; flush = 0; global_stall = 0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int r = 0; r < REG_NUM; r++) ready_at[r] = 0;
    now = 0;
    m_stall = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    drive(1, 5, 1, 6, 1, 7, 1, C_MDU);
    #2;
    if (pause !== 1'b0 || bubble !== 1'b0) begin
      n_fail++; $display("FAIL rst_pause: got %0b/%0b required 0/0", pause, bubble);
    end
    n_tests++;
    if (busy_mask !== '0 || stall_cycles !== '0) begin
      n_fail++; $display("FAIL rst_state: got busy=%h stall=%0d required 0/0", busy_mask, stall_cycles);
    end
    n_tests++;
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, C_LOAD); #1;
    if (pause !== 1'b0) begin n_fail++; $display("FAIL lu_issue: got pause=%0b required 0", pause); end
    n_tests++;
    next();
    drive(1, 5, 1, 0, 0, 6, 1, C_ALU); #1;
    if (pause !== 1'b1 || bubble !== 1'b1 || busy_mask[5] !== 1'b1) begin
      n_fail++; $display("FAIL lu_stall: got p=%0b b=%0b busy5=%0b required 1/1/1", pause, bubble, busy_mask[5]);
    end
    n_tests++;
    next(); #1;
    if (pause !== 1'b0 || stall_cycles !== 32'd1) begin
      n_fail++; $display("FAIL lu_release: got p=%0b stall=%0d required 0/1", pause, stall_cycles);
    end
    n_tests++;
    next(); idle(); #1;
    if (stall_cycles !== 32'd1 || busy_mask !== '0) begin
      n_fail++; $display("FAIL lu_after: got stall=%0d busy=%h required 1/0", stall_cycles, busy_mask);
    end
    n_tests++;
  endtask

  task automatic test_mdu_raw();
    do_reset();
    drive(1, 0, 0, 0, 0, 7, 1, C_MDU); #1;
    next();
    drive(1, 0, 0, 7, 1, 8, 1, C_ALU);
    for (int k = 0; k < MDU_LAT; k++) begin
      #1;
      if (pause !== 1'b1 || busy_mask[7] !== 1'b1) begin
        n_fail++; $display("FAIL mdu_raw_hold%0d: got p=%0b busy7=%0b required 1/1", k, pause, busy_mask[7]);
      end
      n_tests++;
      next();
    end
    #1;
    if (pause !== 1'b0 || busy_mask[7] !== 1'b0 || stall_cycles !== 32'd4) begin
      n_fail++; $display("FAIL mdu_raw_release: got p=%0b busy7=%0b stall=%0d required 0/0/4", pause, busy_mask[7], stall_cycles);
    end
    n_tests++;
    next(); idle();
  endtask

  task automatic test_waw();
    do_reset();
    drive(1, 0, 0, 0, 0, 9, 1, C_MDU); #1;
    next();
    drive(1, 0, 0, 0, 0, 9, 1, C_ALU);
    for (int k = 0; k < MDU_LAT; k++) begin
      #1;
      if (pause !== 1'b1) begin n_fail++; $display("FAIL waw_hold%0d: got p=%0b required 1", k, pause); end
      n_tests++;
      next();
    end
    #1;
    if (pause !== 1'b0 || stall_cycles !== 32'd4) begin
      n_fail++; $display("FAIL waw_release: got p=%0b stall=%0d required 0/4", pause, stall_cycles);
    end
    n_tests++;
    do_reset();
    drive(1, 0, 0, 0, 0, 9, 1, C_MDU); #1;
    next();
    drive(1, 0, 0, 0, 0, 0, 1, C_ALU);
    for (int k = 0; k < MDU_LAT; k++) begin
      #1;
      if (pause !== 1'b0) begin n_fail++; $display("FAIL waw_x0_%0d: got p=%0b required 0", k, pause); end
      n_tests++;
      next();
    end
    if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL waw_x0_cnt: got %0d required 0", stall_cycles); end
    n_tests++;
    idle();
  endtask

  task automatic test_flush_gstall();
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, C_LOAD); #1;
    next();
    drive(1, 5, 1, 0, 0, 6, 1, C_MDU); flush = 1; #1;
    if (pause !== 1'b0 || bubble !== 1'b0) begin
      n_fail++; $display("FAIL flush_force: got p=%0b b=%0b required 0/0", pause, bubble);
    end
    n_tests++;
    next(); idle(); #1;
    if (busy_mask !== '0) begin n_fail++; $display("FAIL flush_noissue: got busy=%h required 0", busy_mask); end
    n_tests++;
    next();
    drive(1, 0, 0, 0, 0, 5, 1, C_LOAD); #1;
    next();
    drive(1, 5, 1, 0, 0, 6, 1, C_MDU); global_stall = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (pause !== 1'b1 || busy_mask[5] !== 1'b1 || busy_mask[6] !== 1'b0) begin
        n_fail++; $display("FAIL gstall_hold%0d: got p=%0b busy5=%0b busy6=%0b required 1/1/0", k, pause, busy_mask[5], busy_mask[6]);
      end
      n_tests++;
      next();
    end
    global_stall = 0; #1;
    if (pause !== 1'b1 || stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL gstall_drop: got p=%0b stall=%0d required 1/0", pause, stall_cycles);
    end
    n_tests++;
    next(); #1;
    if (pause !== 1'b0 || stall_cycles !== 32'd1 || busy_mask[5] !== 1'b0) begin
      n_fail++; $display("FAIL gstall_release: got p=%0b stall=%0d busy5=%0b required 0/1/0", pause, stall_cycles, busy_mask[5]);
    end
    n_tests++;
    next(); idle(); #1;
    if (busy_mask !== REG_NUM'(32'h40)) begin
      n_fail++; $display("FAIL gstall_issue: got busy=%h required 40", busy_mask);
    end
    n_tests++;
  endtask

  task automatic test_load_over_mdu();
    do_reset();
    drive(1, 0, 0, 0, 0, 3, 1, C_MDU); #1;
    next(); idle(); next(); next();
    drive(1, 0, 0, 0, 0, 3, 1, C_LOAD); #1;
    if (pause !== 1'b1 || busy_mask[3] !== 1'b1) begin
      n_fail++; $display("FAIL lom_reject: got p=%0b busy3=%0b required 1/1", pause, busy_mask[3]);
    end
    n_tests++;
    next(); #1;
    if (pause !== 1'b0) begin n_fail++; $display("FAIL lom_accept: got p=%0b required 0", pause); end
    n_tests++;
    next(); idle(); #1;
    if (busy_mask[3] !== 1'b1) begin n_fail++; $display("FAIL lom_reload: got busy3=%0b required 1", busy_mask[3]); end
    n_tests++;
    next(); #1;
    if (busy_mask[3] !== 1'b0) begin n_fail++; $display("FAIL lom_done: got busy3=%0b required 0", busy_mask[3]); end
    n_tests++;
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1, 0, 0, 0, 0, 7, 1, C_MDU); #1;
    next();
    drive(1, 0, 0, 7, 1, 8, 1, C_MDU);
    next(); #1;
    if (pause !== 1'b1 || stall_cycles !== 32'd1) begin
      n_fail++; $display("FAIL arst_pre: got p=%0b stall=%0d required 1/1", pause, stall_cycles);
    end
    n_tests++;
    #1 rst_n = 0;
    #1;
    if (pause !== 1'b0 || bubble !== 1'b0 || busy_mask !== '0 || stall_cycles !== '0) begin
      n_fail++; $display("FAIL arst_now: got p=%0b b=%0b busy=%h stall=%0d required 0/0/0/0", pause, bubble, busy_mask, stall_cycles);
    end
    n_tests++;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    if (pause !== 1'b0 || busy_mask !== REG_NUM'(32'h100) || stall_cycles !== '0) begin
      n_fail++; $display("FAIL arst_release: got p=%0b busy=%h stall=%0d required 0/100/0", pause, busy_mask, stall_cycles);
    end
    n_tests++;
    idle();
  endtask

  task automatic test_random();
    logic exp_p, iss;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      drive(($urandom % 4) != 0, $urandom_range(0, 7), $urandom % 2, $urandom_range(0, 7),
            $urandom % 2, $urandom_range(0, 7), ($urandom % 4) != 0, 2'($urandom % 4));
      flush        = ($urandom % 10) == 0;
      global_stall = ($urandom % 7) == 0;
      #1;
      exp_p = m_pause();
      if (pause !== exp_p || bubble !== exp_p) begin
        n_fail++; $display("FAIL rnd_pause c%0d: got p=%0b b=%0b required %0b", cyc, pause, bubble, exp_p);
      end
      n_tests++;
      if (busy_mask !== m_busy()) begin
        n_fail++; $display("FAIL rnd_busy c%0d: got %h required %h", cyc, busy_mask, m_busy());
      end
      n_tests++;
      if (stall_cycles !== CNT_W'(m_stall)) begin
        n_fail++; $display("FAIL rnd_stall c%0d: got %0d required %0d", cyc, stall_cycles, m_stall);
      end
      n_tests++;
      if (!global_stall) begin
        iss = id_valid && id_reg_write && id_rd_addr != 0 && !exp_p && !flush;
        if (exp_p) m_stall++;
        now++;
        if (iss) ready_at[id_rd_addr] = now + lat(id_class);
      end
      next();
    end
    idle();
  endtask

  initial begin
    rst_n = 0;
    idle();
    test_reset();
    test_load_use();
    test_mdu_raw();
    test_waw();
    test_flush_gstall();
    test_load_over_mdu();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
